// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
// Optional build macro: TT_SWEEP_GRAY_EN (Gray-ordered sweep + glitch flag).
package tt_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  // Number of rows in the truth table of an n-input gate.
  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

  // Reflected binary Gray code of k.
  function automatic int unsigned gray(input int unsigned k);
    return k ^ (k >> 1);
  endfunction

endpackage

// File: rtl/tt_compare_acc.sv
// Per-sample comparison accumulator: counts mismatching table bits and
// remembers the index of the first mismatch seen in sweep order.
module tt_compare_acc #(
  parameter int N_IN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clear,
  input  logic            i_en,
  input  logic [N_IN-1:0] i_idx,
  input  logic            i_bit,
  input  logic            i_exp,
  output logic [N_IN:0]   o_fail_count,
  output logic [N_IN-1:0] o_first_fail
);

  logic [N_IN:0]   r_fail_count;
  logic [N_IN-1:0] r_first_fail;

  // Accumulate mismatches; a zero count means no mismatch has been recorded yet.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_fail_count <= '0;
      r_first_fail <= '0;
    end else if (i_en && (i_bit != i_exp)) begin
      if (r_fail_count == '0) begin
        r_first_fail <= i_idx;
      end
      r_fail_count <= r_fail_count + (N_IN+1)'(1);
    end
  end

  assign o_fail_count = r_fail_count;
  assign o_first_fail = r_first_fail;

endmodule

// File: rtl/tt_sweep_checker.sv
// Truth-table sweep sequencer/checker for one N_IN-input combinational gate.
// Drives every input vector, waits SETTLE_CYCLES, samples the gate output,
// and compares the captured table with the expected table latched at start.
// Optional build macro: TT_SWEEP_GRAY_EN (Gray-ordered sweep + glitch_flag).
module tt_sweep_checker
  import tt_sweep_pkg::*;
#(
  parameter  int N_IN          = 4,
  parameter  int SETTLE_CYCLES = 2,
  localparam int TT_W          = tt_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [TT_W-1:0] tt_expected,
  output logic [N_IN-1:0] stim,
  input  logic            gate_out,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] captured_tt,
  output logic            match,
  output logic [N_IN:0]   fail_count,
  output logic [N_IN-1:0] first_fail
`ifdef TT_SWEEP_GRAY_EN
  ,
  output logic            glitch_flag
`endif
);

  localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] K_LAST      = '1;

  state_t          r_state;
  state_t          w_next;
  logic [N_IN-1:0] r_k;
  logic [N_IN-1:0] r_stim;
  logic [7:0]      r_settle;
  logic [TT_W-1:0] r_exp;
  logic [TT_W-1:0] r_cap;
  logic [TT_W-1:0] w_cap_next;
  logic            r_done;
  logic            r_match;

  logic            w_busy;
  logic            w_accept;
  logic            w_abort;
  logic            w_sample_en;
  logic            w_last_k;
  logic [N_IN-1:0] w_order;

  assign w_busy      = (r_state == DRIVE) || (r_state == SETTLE) || (r_state == SAMPLE);
  // abort outranks start, so a simultaneous start in IDLE/DONE is dropped.
  assign w_accept    = start && !abort && ((r_state == IDLE) || (r_state == DONE));
  assign w_abort     = abort && w_busy;
  assign w_sample_en = (r_state == SAMPLE) && !abort;
  assign w_last_k    = (r_k == K_LAST);

`ifdef TT_SWEEP_GRAY_EN
  assign w_order = N_IN'(gray(32'(r_k)));
`else
  assign w_order = r_k;
`endif

  // Captured table with the bit of the current vector replaced by the live sample.
  always_comb begin
    w_cap_next         = r_cap;
    w_cap_next[r_stim] = gate_out;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (w_accept) w_next = DRIVE;
      DRIVE:      w_next = abort ? IDLE : SETTLE;
      SETTLE: begin
        if (abort)                        w_next = IDLE;
        else if (r_settle == SETTLE_LAST) w_next = SAMPLE;
      end
      SAMPLE: begin
        if (abort)         w_next = IDLE;
        else if (w_last_k) w_next = DONE;
        else               w_next = DRIVE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Sweep datapath: vector counter, stim register, capture, match and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k      <= '0;
      r_stim   <= '0;
      r_settle <= '0;
      r_exp    <= '0;
      r_cap    <= '0;
      r_done   <= 1'b0;
      r_match  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_exp   <= tt_expected;
        r_cap   <= '0;
        r_match <= 1'b0;
        r_k     <= '0;
      end else if (w_abort) begin
        r_stim  <= '0;
        r_match <= 1'b0;
      end else begin
        case (r_state)
          DRIVE: begin
            r_stim   <= w_order;
            r_settle <= '0;
          end
          SETTLE: r_settle <= r_settle + 8'd1;
          SAMPLE: begin
            r_cap <= w_cap_next;
            if (w_last_k) begin
              r_done  <= 1'b1;
              r_match <= (w_cap_next == r_exp);
            end else begin
              r_k <= r_k + N_IN'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  tt_compare_acc #(
    .N_IN (N_IN)
  ) u_acc (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_accept),
    .i_en         (w_sample_en),
    .i_idx        (r_stim),
    .i_bit        (gate_out),
    .i_exp        (r_exp[r_stim]),
    .o_fail_count (fail_count),
    .o_first_fail (first_fail)
  );

`ifdef TT_SWEEP_GRAY_EN
  logic r_prev_gate;
  logic r_glitch;

  // Flag any output movement after the first settle cycle of a vector; the
  // first settle cycle is excluded because the output legitimately changes there.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_gate <= 1'b0;
      r_glitch    <= 1'b0;
    end else begin
      r_prev_gate <= gate_out;
      if (w_accept) begin
        r_glitch <= 1'b0;
      end else if ((r_state == SETTLE) && (r_settle != '0) && (gate_out != r_prev_gate)) begin
        r_glitch <= 1'b1;
      end
    end
  end

  assign glitch_flag = r_glitch;
`endif

  assign stim        = r_stim;
  assign busy        = w_busy;
  assign done        = r_done;
  assign captured_tt = r_cap;
  assign match       = r_match;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Self-checking bench for tt_sweep_checker (N_IN=4, SETTLE_CYCLES=2).
// The gate is modelled as a table lookup; expected results come from
// plain arithmetic on the model and expected tables.
module tb_tt_sweep_checker;

  localparam int N_IN   = 4;
  localparam int SETTLE = 2;
  localparam int TT_W   = 16;
  localparam int LAT    = TT_W * (SETTLE + 2) + 1;
`ifdef TT_SWEEP_GRAY_EN
  localparam logic [3:0] LAST_STIM = 4'b1000;
`else
  localparam logic [3:0] LAST_STIM = 4'b1111;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] tt_expected;
  logic [3:0]  stim;
  logic        gate_out;
  logic        busy;
  logic        done;
  logic [15:0] captured_tt;
  logic        match;
  logic [4:0]  fail_count;
  logic [3:0]  first_fail;
`ifdef TT_SWEEP_GRAY_EN
  logic        glitch_flag;
`endif

  logic [15:0] model;
  logic        g_inj;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  always_comb gate_out = model[stim] ^ g_inj;

  tt_sweep_checker #(
    .N_IN          (N_IN),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .tt_expected (tt_expected),
    .stim        (stim),
    .gate_out    (gate_out),
    .busy        (busy),
    .done        (done),
    .captured_tt (captured_tt),
    .match       (match),
    .fail_count  (fail_count),
    .first_fail  (first_fail)
`ifdef TT_SWEEP_GRAY_EN
    ,
    .glitch_flag (glitch_flag)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_fails(input logic [15:0] m, input logic [15:0] e);
    return $countones(m ^ e);
  endfunction

  function automatic int ref_first(input logic [15:0] m, input logic [15:0] e);
    logic [15:0] d;
    int f;
    d = m ^ e;
    f = 0;
    for (int i = 15; i >= 0; i--) if (d[i]) f = i;
    return f;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_stim"},  32'(stim), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_cap"},   32'(captured_tt), 0);
    chk({tag, "_match"}, 32'(match), 0);
    chk({tag, "_fcnt"},  32'(fail_count), 0);
    chk({tag, "_ffst"},  32'(first_fail), 0);
  endtask

  // Start a sweep and wait for done; optionally retries start at cycle restart_at
  // with an all-zero expected table (must be ignored while busy).
  task automatic sweep(input logic [15:0] m, input logic [15:0] e, input int restart_at,
                       input int inj_at, output int lat);
    logic [3:0] prev;
    int cnt;
    model = m;
    tt_expected = e;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 1;
    prev = stim;
    while (!done && cnt < 200) begin
      if (cnt == restart_at) begin
        start = 1'b1;
        tt_expected = '0;
      end
      g_inj = (cnt == inj_at);
      @(posedge clk); #1;
      start = 1'b0;
      g_inj = 1'b0;
      cnt++;
`ifdef TT_SWEEP_GRAY_EN
      if (stim !== prev) chk("gray_step", 32'($countones(stim ^ prev)), 1);
`endif
      prev = stim;
    end
    lat = cnt;
  endtask

  task automatic run_and_check(input logic [15:0] m, input logic [15:0] e, input int restart_at);
    int lat;
    sweep(m, e, restart_at, -1, lat);
    chk("latency",    32'(lat), LAT);
    chk("captured",   32'(captured_tt), 32'(m));
    chk("match",      32'(match), 32'(m == e));
    chk("fail_count", 32'(fail_count), 32'(ref_fails(m, e)));
    chk("first_fail", 32'(first_fail), 32'(ref_first(m, e)));
`ifdef TT_SWEEP_GRAY_EN
    chk("glitch_clean", 32'(glitch_flag), 0);
`endif
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 0);
    chk("stim_hold",  32'(stim), 32'(LAST_STIM));
    chk("cap_hold",   32'(captured_tt), 32'(m));
  endtask

  initial begin
    int cnt;
    int seen;
    int lat;
    logic [15:0] m;
    logic [15:0] e;

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    tt_expected = '0; model = '0; g_inj = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed sweeps.
    run_and_check(16'h4A32, 16'h4A32, -1);
    run_and_check(16'h4A32, 16'h4A33, -1);
    run_and_check(16'h0000, 16'hFFFF, -1);
    run_and_check(16'h4A32, 16'h4A32, 10);

    // Abort while settling vector 4: vectors 0..3 already captured.
    model = 16'h4A32; tt_expected = 16'h4A32; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 1;
    while (cnt < 19) begin
      @(posedge clk); #1;
      cnt++;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy",  32'(busy), 0);
    chk("abort_stim",  32'(stim), 0);
    chk("abort_match", 32'(match), 0);
    chk("abort_cap",   32'(captured_tt), 32'(16'h4A32 & 16'h000F));
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("abort_no_done", 32'(seen), 0);
    chk("abort_idle",    32'(busy), 0);

    // Reset while settling vector 7, then a normal sweep.
    model = 16'h4A32; tt_expected = 16'h4A32; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 1;
    while (cnt < 30) begin
      @(posedge clk); #1;
      cnt++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    run_and_check(16'h4A32, 16'h4A32, -1);

    // Randomized tables: exact match, single-bit difference, unrelated.
    for (int i = 0; i < 9; i++) begin
      m = 16'($urandom);
      case (i % 3)
        0:       e = m;
        1:       e = m ^ (16'd1 << $urandom_range(15, 0));
        default: e = 16'($urandom);
      endcase
      run_and_check(m, e, -1);
    end

`ifdef TT_SWEEP_GRAY_EN
    // Disturb the gate output during the second settle cycle of vector 0.
    sweep(16'h4A32, 16'h4A32, -1, 3, lat);
    chk("glitch_lat",  32'(lat), LAT);
    chk("glitch_set",  32'(glitch_flag), 1);
    chk("glitch_cap",  32'(captured_tt), 32'(16'h4A32));
    run_and_check(16'h4A32, 16'h4A32, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
